// File: rtl/rti_pkg.sv
// Shared types and widths for the real-time input capture core.
package rti_pkg;

    localparam int TS_W    = 64;
    localparam int ENTRY_W = 128;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [63:0]     data;
    } rti_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } rti_state_t;

    function automatic rti_entry_t make_entry(input logic [TS_W-1:0] ts,
                                              input logic [63:0]     data);
        rti_entry_t e;
        e.ts   = ts;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/rti_sync_fifo.sv
// First-word-fall-through single-clock FIFO with a registered head entry and
// an early "full" threshold below the physical depth.
module rti_sync_fifo
    import rti_pkg::*;
#(
    parameter  int DEPTH       = 1024,
    parameter  int FULL_THRESH = 1000,
    localparam int AW          = $clog2(DEPTH),
    localparam int CNT_W       = AW + 1
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               wr,
    input  logic               rd,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic [CNT_W-1:0]   count
);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [AW-1:0]      rd_ptr_inc_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic [ENTRY_W-1:0] head_r;
    logic [ENTRY_W-1:0] head_next_s;
    logic               empty_r;
    logic               full_r;
    logic               wr_s;
    logic               rd_s;

    assign wr_s         = wr & ~full_r & ~srst;
    assign rd_s         = rd & ~empty_r;
    assign rd_ptr_inc_s = rd_ptr_r + AW'(1);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({wr_s, rd_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Next head: the entry being written bypasses the array when it lands
    // on the slot that becomes the head.
    always_comb begin
        head_next_s = head_r;
        if (count_next_s == CNT_W'(0)) begin
            head_next_s = {ENTRY_W{1'b0}};
        end else if (wr_s && ((count_r == CNT_W'(0)) || (rd_s && (count_r == CNT_W'(1))))) begin
            head_next_s = din;
        end else if (rd_s) begin
            head_next_s = mem_r[rd_ptr_inc_s];
        end else begin
            head_next_s = head_r;
        end
    end

    // Storage array, deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and registered status/head.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            head_r   <= {ENTRY_W{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            count_r <= count_next_s;
            head_r  <= head_next_s;
            empty_r <= (count_next_s == CNT_W'(0));
            full_r  <= (count_next_s >= CNT_W'(FULL_THRESH));
        end
    end

    assign dout  = head_r;
    assign empty = empty_r;
    assign full  = full_r;
    assign count = count_r;

endmodule

// File: rtl/rti_core.sv
// Real-time input capture: timestamps every change of sig_in while armed and
// queues {counter, data}. Optional macro RTI_DROP_COUNT_EN adds dropped_count.
module rti_core
    import rti_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 1024,
    parameter int FULL_THRESH = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     auto_start,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        sig_in,
    input  logic [TS_W-1:0]          counter,
    input  logic                     read,
    output logic [ENTRY_W-1:0]       rti_out,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow_error,
    output logic [ENTRY_W-1:0]       overflow_error_data,
    output logic                     underflow_error,
    output logic [$clog2(DEPTH):0]   count
`ifdef RTI_DROP_COUNT_EN
    ,
    output logic [31:0]              dropped_count
`endif
);

    rti_state_t         state_r;
    rti_state_t         state_next_s;
    logic [DATA_W-1:0]  sig_q_r;
    logic               load_q_s;
    logic               event_s;
    logic               srst_s;
    logic               wr_s;
    logic               drop_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic [63:0]        data_ext_s;
    rti_entry_t         entry_s;
    logic               overflow_error_r;
    logic [ENTRY_W-1:0] overflow_error_data_r;
    logic               underflow_error_r;

    assign srst_s = reset | flush;

    // Zero-extend the sampled bus into the 64-bit data field.
    always_comb begin
        data_ext_s               = 64'd0;
        data_ext_s[DATA_W-1:0]   = sig_in;
    end

    assign entry_s = make_entry(counter, data_ext_s);

    // Capture FSM: PRIME takes a baseline, RUN flags every change.
    always_comb begin
        state_next_s = state_r;
        load_q_s     = 1'b0;
        event_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (auto_start) begin
                    state_next_s = PRIME;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PRIME: begin
                load_q_s     = 1'b1;
                state_next_s = RUN;
            end
            RUN: begin
                load_q_s = 1'b1;
                if (auto_start) begin
                    event_s      = (sig_in != sig_q_r);
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign wr_s   = event_s & ~fifo_full_s;
    assign drop_s = event_s & fifo_full_s;

    // State and baseline registers.
    always_ff @(posedge clk) begin
        if (srst_s) begin
            state_r <= IDLE;
            sig_q_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (load_q_s) begin
                sig_q_r <= sig_in;
            end
        end
    end

    // Error pulses; the dropped entry is kept until the next drop.
    always_ff @(posedge clk) begin
        if (srst_s) begin
            overflow_error_r      <= 1'b0;
            overflow_error_data_r <= {ENTRY_W{1'b0}};
            underflow_error_r     <= 1'b0;
        end else begin
            overflow_error_r  <= drop_s;
            underflow_error_r <= read & fifo_empty_s;
            if (drop_s) begin
                overflow_error_data_r <= entry_s;
            end
        end
    end

`ifdef RTI_DROP_COUNT_EN
    logic [31:0] dropped_count_r;

    // Saturating count of dropped events.
    always_ff @(posedge clk) begin
        if (srst_s) begin
            dropped_count_r <= 32'd0;
        end else if (drop_s && (dropped_count_r != 32'hFFFF_FFFF)) begin
            dropped_count_r <= dropped_count_r + 32'd1;
        end
    end

    assign dropped_count = dropped_count_r;
`endif

    rti_sync_fifo #(
        .DEPTH       (DEPTH),
        .FULL_THRESH (FULL_THRESH)
    ) u_fifo (
        .clk   (clk),
        .srst  (srst_s),
        .wr    (wr_s),
        .rd    (read),
        .din   (entry_s),
        .dout  (rti_out),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .count (count)
    );

    assign empty               = fifo_empty_s;
    assign full                = fifo_full_s;
    assign overflow_error      = overflow_error_r;
    assign overflow_error_data = overflow_error_data_r;
    assign underflow_error     = underflow_error_r;

endmodule

// File: tb/tb_rti_core.sv
// Randomized bench for rti_core against a queue-based reference model.
module tb_rti_core;

    localparam int THRESH = 1000;
    localparam int DEPTH  = 1024;

    logic         clk = 1'b0;
    logic         reset;
    logic         auto_start;
    logic         flush;
    logic [63:0]  sig_in;
    logic [63:0]  counter;
    logic         read;
    logic [127:0] rti_out;
    logic         empty;
    logic         full;
    logic         overflow_error;
    logic [127:0] overflow_error_data;
    logic         underflow_error;
    logic [10:0]  count;
`ifdef RTI_DROP_COUNT_EN
    logic [31:0]  dropped_count;
`endif

    rti_core #(.DATA_W(64), .DEPTH(DEPTH), .FULL_THRESH(THRESH)) dut (
        .clk                 (clk),
        .reset               (reset),
        .auto_start          (auto_start),
        .flush               (flush),
        .sig_in              (sig_in),
        .counter             (counter),
        .read                (read),
        .rti_out             (rti_out),
        .empty               (empty),
        .full                (full),
        .overflow_error      (overflow_error),
        .overflow_error_data (overflow_error_data),
        .underflow_error     (underflow_error),
        .count               (count)
`ifdef RTI_DROP_COUNT_EN
        ,
        .dropped_count       (dropped_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: capture armed/baseline bookkeeping plus a plain queue.
    logic [127:0] mq[$];
    int           m_mode;     // 0 = not armed, 1 = taking baseline, 2 = capturing
    logic [63:0]  m_base;
    logic         m_ovf;
    logic [127:0] m_ovf_data;
    logic         m_unf;
    longint       m_drop;
    longint       tl;
    logic [127:0] last_ent;
    int           n_total = 0;
    int           n_bad   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] new_val(input logic [63:0] cur);
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        if (v == cur) v = ~cur;
        return v;
    endfunction

    // Advance one clock: update the model from current inputs, then compare.
    task automatic step();
        logic [127:0] ent;
        logic         ev;
        int           sz;
        ent = {counter, sig_in};
        sz  = mq.size();
        if (reset || flush) begin
            mq.delete();
            m_mode = 0; m_base = 64'd0; m_ovf = 1'b0; m_ovf_data = 128'd0;
            m_unf = 1'b0; m_drop = 0;
        end else begin
            ev    = (m_mode == 2) && auto_start && (sig_in != m_base);
            m_unf = read && (sz == 0);
            m_ovf = ev && (sz >= THRESH);
            if (m_ovf) begin
                m_ovf_data = ent;
                if (m_drop < 64'hFFFF_FFFF) m_drop++;
            end
            if (read && sz > 0) void'(mq.pop_front());
            if (ev && sz < THRESH) mq.push_back(ent);
            if (m_mode != 0) m_base = sig_in;
            if (m_mode == 0) m_mode = auto_start ? 1 : 0;
            else if (m_mode == 1) m_mode = 2;
            else m_mode = auto_start ? 2 : 0;
        end
        @(posedge clk);
        #1;
        check_val("empty", 128'(empty), 128'(mq.size() == 0));
        check_val("count", 128'(count), 128'(mq.size()));
        check_val("full", 128'(full), 128'(mq.size() >= THRESH));
        check_val("head", rti_out, (mq.size() > 0) ? mq[0] : 128'd0);
        check_val("ovf", 128'(overflow_error), 128'(m_ovf));
        check_val("ovf_data", overflow_error_data, m_ovf_data);
        check_val("unf", 128'(underflow_error), 128'(m_unf));
`ifdef RTI_DROP_COUNT_EN
        check_val("dropped", 128'(dropped_count), 128'(m_drop));
`endif
        tl++;
        counter = 64'(tl);
    endtask

    task automatic do_reset();
        reset = 1'b1; auto_start = 1'b0; flush = 1'b0; read = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic arm();
        auto_start = 1'b1;
        step();
        step();
    endtask

    task automatic fill(input int n, input logic rd);
        for (int i = 0; i < n; i++) begin
            sig_in   = new_val(sig_in);
            read     = rd;
            last_ent = {counter, sig_in};
            step();
        end
        read = 1'b0;
    endtask

    task automatic drain(input int n);
        read = 1'b1;
        for (int i = 0; i < n; i++) step();
        read = 1'b0;
    endtask

    initial begin
        reset = 1'b1; auto_start = 1'b0; flush = 1'b0; read = 1'b0;
        sig_in = 64'd0; tl = 0; counter = 64'd0;
        m_mode = 0; m_base = 64'd0; m_ovf = 1'b0; m_ovf_data = 128'd0; m_unf = 1'b0; m_drop = 0;

        // Reset state
        do_reset();
        step();
        check_val("rst_empty", 128'(empty), 128'd1);
        check_val("rst_count", 128'(count), 128'd0);

        // First capture with known timestamp
        sig_in = 64'd0;
        arm();
        tl = 100; counter = 64'd100;
        sig_in = 64'd5;
        step();
        check_val("tp1_head", rti_out, {64'd100, 64'd5});
        check_val("tp1_nonempty", 128'(empty), 128'd0);
        drain(1);
        check_val("tp1_drained", 128'(empty), 128'd1);

        // Value present before arming gives no entry
        do_reset();
        sig_in = 64'hA;
        arm();
        step();
        check_val("tp2_none", 128'(count), 128'd0);
        tl = 200; counter = 64'd200;
        sig_in = 64'hB;
        step();
        check_val("tp2_head", rti_out, {64'd200, 64'hB});
        check_val("tp2_count", 128'(count), 128'd1);

        // Fill to threshold, then overflow
        do_reset();
        arm();
        fill(THRESH, 1'b0);
        check_val("tp3_full", 128'(full), 128'd1);
        check_val("tp3_count", 128'(count), 128'(THRESH));
        fill(1, 1'b0);
        check_val("tp3_ovf", 128'(overflow_error), 128'd1);
        check_val("tp3_ovf_data", overflow_error_data, last_ent);
        check_val("tp3_count_hold", 128'(count), 128'(THRESH));
        fill(2, 1'b0);
        check_val("tp3_ovf_b2b", 128'(overflow_error), 128'd1);
        step();
        check_val("tp3_ovf_end", 128'(overflow_error), 128'd0);
        drain(THRESH);

        // Simultaneous write and read with one entry
        do_reset();
        arm();
        fill(1, 1'b0);
        fill(1, 1'b1);
        check_val("tp4_count", 128'(count), 128'd1);
        check_val("tp4_head", rti_out, last_ent);

        // Underflow
        do_reset();
        read = 1'b1;
        step();
        read = 1'b0;
        check_val("tp5_unf", 128'(underflow_error), 128'd1);
        step();
        check_val("tp5_unf_end", 128'(underflow_error), 128'd0);
        check_val("tp5_count", 128'(count), 128'd0);

        // Pointer wrap, then flush mid-stream
        do_reset();
        arm();
        fill(600, 1'b0);
        drain(600);
        fill(600, 1'b0);
        drain(300);
        fill(5, 1'b0);
        flush = 1'b1;
        sig_in = new_val(sig_in);
        step();
        flush = 1'b0;
        check_val("flush_empty", 128'(empty), 128'd1);
        check_val("flush_count", 128'(count), 128'd0);
        step();                                  // not yet armed again
        fill(1, 1'b0);                           // baseline cycle: no entry
        check_val("flush_prime", 128'(count), 128'd0);
        fill(1, 1'b0);
        check_val("flush_run", 128'(count), 128'd1);
        drain(310);

        // Randomized traffic: fill-biased first half, drain-biased second half
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            int ev_pct;
            int rd_pct;
            ev_pct     = (i < 2500) ? 75 : 25;
            rd_pct     = (i < 2500) ? 25 : 75;
            auto_start = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 99) < ev_pct) sig_in = new_val(sig_in);
            read  = ($urandom_range(0, 99) < rd_pct);
            flush = ($urandom_range(0, 999) == 0);
            reset = ($urandom_range(0, 1999) == 0);
            step();
        end
        reset = 1'b0; flush = 1'b0; read = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rti_core.md
Name: rti_core

Overview:
Real-time input capture queue, the receive-side counterpart of the timed-output core. Watches a parallel input bus and, on every change while armed, timestamps the new value with the shared 64-bit timeline counter. Pushes a 128-bit entry {timestamp[127:64], data[63:0]} into an internal FIFO. The host/AXI side drains the FIFO using the same entry format the output core consumes.

Parameters:
DATA_W, 64, width of sampled input bus (1..64); zero-extended into entry[63:0]
DEPTH, 1024, FIFO depth in entries (power of two)
FULL_THRESH, 1000, occupancy at which full asserts (< DEPTH, absorbs host latency)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
auto_start  in  1  capture enable; level
flush  in  1  synchronous FIFO/state clear, same effect as reset
sig_in  in  DATA_W  sampled input bus, already synchronised to clk
counter  in  64  timeline counter, same source as the output core
read  in  1  pop head entry
rti_out  out  128  FIFO head entry (first-word-fall-through); valid when empty=0
empty  out  1  FIFO empty
full  out  1  occupancy >= FULL_THRESH
overflow_error  out  1  one-cycle pulse: event dropped because full
overflow_error_data  out  128  last dropped entry
underflow_error  out  1  one-cycle pulse: read while empty
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset/flush (either high at posedge): FIFO emptied; empty=1, full=0, count=0, rti_out=0; both error pulses 0; overflow_error_data=0; sig_q=0; FSM to IDLE.
- FSM states:
  - IDLE: no capture. auto_start=1 -> PRIME.
  - PRIME: one cycle; sig_q<=sig_in as baseline, no event generated -> RUN.
  - RUN: each cycle, event = (sig_in != sig_q); sig_q<=sig_in. auto_start=0 -> IDLE (no event in that cycle).
- Entry formed combinationally in the event cycle: {counter, zero-extended sig_in}. The timestamp is the counter value in the same cycle the changed value first appears on sig_in.
- Write: wr = event && !full. Entry written at the posedge closing the event cycle.
  - Write into an empty FIFO: empty=0 and rti_out=entry in the next cycle (1-cycle latency).
- Drop: event && full -> no write. overflow_error=1 next cycle; overflow_error_data<=entry.
  - Back-to-back drops: pulse stays high; data holds the latest entry.
- Read: rd = read && !empty. Head advances at the posedge; next head visible the following cycle.
  - read && empty -> underflow_error=1 next cycle; state unchanged.
- Simultaneous wr and rd: count unchanged.
  - Simultaneous wr and rd with one entry stored: new entry becomes head next cycle, empty stays 0.
  - full is evaluated on the registered count; a read in the same cycle does not unblock a write.
- Write pointer, read pointer and count are modular over DEPTH (wrap with no gap). count never exceeds FULL_THRESH.
- Reset/flush mid-RUN: discards all entries; a pending event in that cycle is lost; a new PRIME is needed.
- counter wrap (0xFFFF..F -> 0) is not treated specially; entries carry the raw value.

Optional Feature:
RTI_DROP_COUNT_EN:
- Defined: adds output dropped_count[31:0]. It increments on every overflow drop, saturates at 0xFFFFFFFF, and is cleared by reset/flush.
- Undefined: port and logic are absent; overflow behaviour is otherwise identical.

Decomposition:
- Package rti_pkg:
  - TS_W=64, ENTRY_W=128
  - typedef struct packed {logic [63:0] ts; logic [63:0] data;} rti_entry_t
  - typedef enum {IDLE, PRIME, RUN} rti_state_t
- Sub-module rti_sync_fifo: FWFT single-clock FIFO, parameterised DEPTH/FULL_THRESH, ENTRY_W wide, ports wr/rd/din/dout/empty/full/count, sync active-high srst. rti_core holds the FSM, edge detection and error capture.

Test Plan:
- Reset, auto_start=1, sig_in 0->0x5 at counter=100 -> empty=0 at counter=101, rti_out=0x0000000000000064_0000000000000005; read -> empty=1.
- sig_in already 0xA when auto_start rises -> no entry from PRIME. Change to 0xB at counter=200 -> single entry {200,0xB}.
- Toggle sig_in every cycle for 1000 cycles without reads -> full=1 at count=1000. Next change -> overflow_error pulse and overflow_error_data holds that entry; count stays 1000. With RTI_DROP_COUNT_EN, dropped_count=1.
- One entry stored; event and read in the same cycle -> count stays 1, new entry becomes head next cycle.
- read while empty -> underflow_error for exactly one cycle, count=0.
- Fill 600, read 600, fill 600 (pointer wrap) -> all entries read back in order with correct timestamps. Then flush mid-stream -> empty=1, count=0, FSM returns to PRIME before capturing again.
